// File: rtl/mips_pkg.sv
// Shared definitions for the mips board-level block.
// Holds the parameter defaults, the active-low 7-segment code table
// ({dp,g,f,e,d,c,b,a}, dp always off), the UART transmitter state type and a
// nibble-to-segment helper.
package mips_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 4;
  localparam int unsigned BAUD_DIV_DEFAULT = 8;
  localparam int unsigned SCAN_DIV_DEFAULT = 1024;

  // Element i is the segment code for hex digit i (element 0 in the LSBs).
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single push-key conditioner: 2-flop synchronizer plus debouncer.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous reset, active-high
//   key_n     - raw active-low key, asynchronous to clk
//   key_event - one-cycle pulse, once per accepted press
// A press is accepted after DEBOUNCE consecutive synchronized-low samples and
// the key must be seen released before the next press can be accepted.
module key_debounce
  import mips_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_event
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [1:0]    sync_q;
  logic [1:0]    warm_q;
  logic [CW-1:0] low_cnt;
  logic          latched;

  // warm_q masks the synchronizer's reset value for the first two cycles, and
  // latched starts set, so a key held through reset release needs a real
  // release before it can be accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '1;
      warm_q    <= '0;
      low_cnt   <= '0;
      latched   <= 1'b1;
      key_event <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_n};
      warm_q    <= {warm_q[0], 1'b1};
      key_event <= 1'b0;
      if (warm_q[1]) begin
        if (sync_q[1]) begin
          low_cnt <= '0;
          latched <= 1'b0;
        end else if (!latched) begin
          if (low_cnt == CW'(DEBOUNCE - 1)) begin
            key_event <= 1'b1;
            latched   <= 1'b1;
            low_cnt   <= '0;
          end else begin
            low_cnt <= low_cnt + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/mips.sv
// Board-level demo block: key-driven 32-bit counter with LED, UART and
// 7-segment readout.
// Ports:
//   clk_in, sys_rstn           - clock; asynchronous reset, active-high
//   uart_rxd / uart_txd        - unused input; 8N1 transmitter of count[7:0]
//   uart_rxd2 / uart_txd2      - combinational loopback
//   dip_switch0..7             - switch levels; 3..0 form the load value
//   user_key                   - active-low keys; [0] increments, [1] loads
//   led_light                  - active-low view of count
//   digital_tube0/1, sel0/1    - scanned banks for count[15:0] / count[31:16]
//   digital_tube2, sel2        - static digit for count[3:0]
module mips
  import mips_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT,
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT,
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic        clk_in,
  input  logic        sys_rstn,
  input  logic        uart_rxd,
  output logic        uart_txd,
  input  logic        uart_rxd2,
  output logic        uart_txd2,
  input  logic [7:0]  dip_switch0,
  input  logic [7:0]  dip_switch1,
  input  logic [7:0]  dip_switch2,
  input  logic [7:0]  dip_switch3,
  input  logic [7:0]  dip_switch4,
  input  logic [7:0]  dip_switch5,
  input  logic [7:0]  dip_switch6,
  input  logic [7:0]  dip_switch7,
  input  logic [7:0]  user_key,
  output logic [31:0] led_light,
  output logic [7:0]  digital_tube0,
  output logic [7:0]  digital_tube1,
  output logic [3:0]  digital_tube_sel0,
  output logic [3:0]  digital_tube_sel1,
  output logic [7:0]  digital_tube2,
  output logic        digital_tube_sel2
);

  localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic unused_inputs;
  assign unused_inputs = ^{uart_rxd, dip_switch4, dip_switch5, dip_switch6,
                           dip_switch7, user_key[7:2]};

  // ---------------- keys ----------------
  logic key0_event;
  logic key1_event;

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key0 (
    .clk       (clk_in),
    .rst       (sys_rstn),
    .key_n     (user_key[0]),
    .key_event (key0_event)
  );

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key1 (
    .clk       (clk_in),
    .rst       (sys_rstn),
    .key_n     (user_key[1]),
    .key_event (key1_event)
  );

  // ---------------- counter ----------------
  logic [31:0] count;
  logic [31:0] next_count;
  logic        count_upd;

  always_comb begin
    next_count = count;
    if (key1_event) begin
      next_count = {dip_switch3, dip_switch2, dip_switch1, dip_switch0};
    end else if (key0_event) begin
      next_count = count + 32'd1;
    end
  end

  assign count_upd = key0_event | key1_event;

  always_ff @(posedge clk_in or posedge sys_rstn) begin
    if (sys_rstn) begin
      count <= '0;
    end else if (count_upd) begin
      count <= next_count;
    end
  end

  assign led_light = ~count;

  // ---------------- UART transmitter ----------------
  tx_state_t     tx_state;
  logic [BW-1:0] tx_baud;
  logic [3:0]    tx_bit;
  logic [9:0]    tx_frame;
  logic          tx_pending;
  logic          tx_txd;
  logic          bit_done;
  logic          frame_done;
  logic          tx_start;
  logic [7:0]    tx_byte;

  assign bit_done   = (tx_state == TX_SEND) && (tx_baud == BW'(BAUD_DIV - 1));
  assign frame_done = bit_done && (tx_bit == 4'd9);
  // A new frame may start in the same cycle the previous stop bit ends; an
  // update landing on that cycle sends its fresh value and absorbs any pending.
  assign tx_start   = ((tx_state == TX_IDLE) || frame_done) && (count_upd || tx_pending);
  assign tx_byte    = count_upd ? next_count[7:0] : count[7:0];

  always_ff @(posedge clk_in or posedge sys_rstn) begin
    if (sys_rstn) begin
      tx_state   <= TX_IDLE;
      tx_baud    <= '0;
      tx_bit     <= '0;
      tx_frame   <= '1;
      tx_pending <= 1'b0;
      tx_txd     <= 1'b1;
    end else if (tx_start) begin
      tx_state   <= TX_SEND;
      tx_baud    <= '0;
      tx_bit     <= '0;
      tx_frame   <= {1'b1, tx_byte, 1'b0};
      tx_pending <= 1'b0;
      tx_txd     <= 1'b0;
    end else begin
      if (count_upd) begin
        tx_pending <= 1'b1;
      end
      if (tx_state == TX_SEND) begin
        if (bit_done) begin
          tx_baud <= '0;
          if (frame_done) begin
            tx_state <= TX_IDLE;
            tx_txd   <= 1'b1;
          end else begin
            tx_bit <= tx_bit + 4'd1;
            tx_txd <= tx_frame[tx_bit + 4'd1];
          end
        end else begin
          tx_baud <= tx_baud + BW'(1);
        end
      end
    end
  end

  assign uart_txd  = tx_txd;
  assign uart_txd2 = uart_rxd2;

  // ---------------- 7-segment scanner ----------------
  logic [SW-1:0] scan_cnt;
  logic [1:0]    scan_idx;
  logic [15:0]   count_hi;

  always_ff @(posedge clk_in or posedge sys_rstn) begin
    if (sys_rstn) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  assign count_hi          = count[31:16];
  assign digital_tube_sel0 = 4'b0001 << scan_idx;
  assign digital_tube_sel1 = 4'b0001 << scan_idx;
  assign digital_tube0     = hex_to_seg(count[{scan_idx, 2'b00} +: 4]);
  assign digital_tube1     = hex_to_seg(count_hi[{scan_idx, 2'b00} +: 4]);
  assign digital_tube2     = hex_to_seg(count[3:0]);
  assign digital_tube_sel2 = 1'b1;

endmodule

// File: tb/tb_mips.sv
module tb_mips;

  localparam int DB = 4;
  localparam int BD = 8;
  localparam int SD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rxd, uart_txd, uart_rxd2, uart_txd2;
  logic [7:0]  dip0, dip1, dip2, dip3, dip4, dip5, dip6, dip7;
  logic [7:0]  user_key;
  logic [31:0] led_light;
  logic [7:0]  tube0, tube1, tube2;
  logic [3:0]  sel0, sel1;
  logic        sel2;

  always #5 clk = ~clk;

  mips #(.DEBOUNCE(DB), .BAUD_DIV(BD), .SCAN_DIV(SD)) dut (
    .clk_in            (clk),
    .sys_rstn          (rst),
    .uart_rxd          (uart_rxd),
    .uart_txd          (uart_txd),
    .uart_rxd2         (uart_rxd2),
    .uart_txd2         (uart_txd2),
    .dip_switch0       (dip0),
    .dip_switch1       (dip1),
    .dip_switch2       (dip2),
    .dip_switch3       (dip3),
    .dip_switch4       (dip4),
    .dip_switch5       (dip5),
    .dip_switch6       (dip6),
    .dip_switch7       (dip7),
    .user_key          (user_key),
    .led_light         (led_light),
    .digital_tube0     (tube0),
    .digital_tube1     (tube1),
    .digital_tube_sel0 (sel0),
    .digital_tube_sel1 (sel1),
    .digital_tube2     (tube2),
    .digital_tube_sel2 (sel2)
  );

  logic [7:0] seg_ref [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Key press: raw level sampled low on DB consecutive clocks (after a release)
  // changes count 3 clocks after the DB-th sample. UART: each update asks for a
  // 10*BD-cycle frame; updates during a frame collapse into one follow-up frame.
  logic [31:0] m_count;
  int          m_cyc;
  int          run [2];
  bit          blocked [2];
  int          due0 [$];
  int          due1 [$];
  int          m_rem;
  bit          m_pend;
  logic [7:0]  exp_q [$];
  logic [7:0]  got_bytes [$];
  bit          mon_en;

  always @(posedge clk) begin
    bit ld, inc, upd;
    if (rst) begin
      m_count = '0; m_cyc = 0; m_rem = 0; m_pend = 0;
      for (int k = 0; k < 2; k++) begin run[k] = 0; blocked[k] = 1; end
      due0.delete(); due1.delete(); exp_q.delete();
    end else begin
      m_cyc++;
      ld  = (due1.size() > 0) && (due1[0] == m_cyc);
      inc = (due0.size() > 0) && (due0[0] == m_cyc);
      if (ld)  void'(due1.pop_front());
      if (inc) void'(due0.pop_front());
      upd = ld | inc;
      if (ld) m_count = {dip3, dip2, dip1, dip0};
      else if (inc) m_count = m_count + 1;
      if (m_rem > 0) m_rem--;
      if (m_rem == 0 && (upd || m_pend)) begin
        exp_q.push_back(m_count[7:0]);
        m_rem = 10 * BD;
        m_pend = 0;
      end else if (upd) begin
        m_pend = 1;
      end
      for (int k = 0; k < 2; k++) begin
        if (user_key[k]) begin
          run[k] = 0; blocked[k] = 0;
        end else if (!blocked[k]) begin
          run[k]++;
          if (run[k] == DB) begin
            if (k == 0) due0.push_back(m_cyc + 3); else due1.push_back(m_cyc + 3);
            blocked[k] = 1; run[k] = 0;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int idx;
    logic [15:0] lo, hi;
    if (!rst) begin
      idx = (m_cyc / SD) % 4;
      lo = m_count[15:0] >> (4 * idx);
      hi = m_count[31:16] >> (4 * idx);
      chk("led_light", led_light, ~m_count);
      chk("tube2", {24'd0, tube2}, {24'd0, seg_ref[m_count[3:0]]});
      chk("sel0", {28'd0, sel0}, 32'd1 << idx);
      chk("sel1", {28'd0, sel1}, 32'd1 << idx);
      chk("tube0", {24'd0, tube0}, {24'd0, seg_ref[lo[3:0]]});
      chk("tube1", {24'd0, tube1}, {24'd0, seg_ref[hi[3:0]]});
      chk("sel2", {31'd0, sel2}, 32'd1);
      chk("txd2", {31'd0, uart_txd2}, {31'd0, uart_rxd2});
    end
  end

  // ---------------- UART monitor ----------------
  always begin
    logic prev_txd;
    logic [7:0] b;
    prev_txd = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && prev_txd && !uart_txd) begin
        repeat (BD / 2) @(negedge clk);
        chk("uart_start", {31'd0, uart_txd}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (BD) @(negedge clk);
        chk("uart_stop", {31'd0, uart_txd}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("uart_unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
        end else begin
          chk("uart_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
        end
        got_bytes.push_back(b);
      end
      prev_txd = uart_txd;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int k, input int len);
    @(posedge clk); #1 user_key[k] = 1'b0;
    repeat (len) @(posedge clk);
    #1 user_key[k] = 1'b1;
  endtask

  task automatic press_both(input int len);
    @(posedge clk); #1 user_key[1:0] = 2'b00;
    repeat (len) @(posedge clk);
    #1 user_key[1:0] = 2'b11;
  endtask

  initial begin
    int nb;
    bit found;
    rst = 1'b1; user_key = 8'hFF; uart_rxd = 1'b1; uart_rxd2 = 1'b1; mon_en = 1'b1;
    {dip0, dip1, dip2, dip3, dip4, dip5, dip6, dip7} = '0;

    // values held while in reset
    #2;
    chk("rst_led", led_light, 32'hFFFF_FFFF);
    chk("rst_txd", {31'd0, uart_txd}, 32'd1);
    chk("rst_sel0", {28'd0, sel0}, 32'h1);
    chk("rst_sel1", {28'd0, sel1}, 32'h1);
    chk("rst_tube0", {24'd0, tube0}, 32'hC0);
    chk("rst_tube1", {24'd0, tube1}, 32'hC0);
    chk("rst_tube2", {24'd0, tube2}, 32'hC0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    idle(5);
    chk("post_rst_led", led_light, 32'hFFFF_FFFF);
    chk("post_rst_txd", {31'd0, uart_txd}, 32'd1);
    chk("post_rst_tube0", {24'd0, tube0}, 32'hC0);

    // nine increments
    for (int i = 0; i < 9; i++) begin
      press(0, 5);
      idle(1000);
    end
    chk("nine_led", led_light, 32'hFFFF_FFF6);
    chk("nine_tube2", {24'd0, tube2}, 32'h90);
    chk("nine_frames", got_bytes.size(), 9);
    for (int i = 0; i < 9 && i < got_bytes.size(); i++)
      chk("nine_frame_byte", {24'd0, got_bytes[i]}, i + 1);

    // glitch shorter than the debounce window
    press(0, 3);
    idle(200);
    chk("glitch_led", led_light, 32'hFFFF_FFF6);
    chk("glitch_frames", got_bytes.size(), 9);

    // load from switches
    dip3 = 8'h12; dip2 = 8'h34; dip1 = 8'h56; dip0 = 8'h78;
    press(1, 5);
    idle(20);
    chk("load_led", led_light, 32'hEDCB_A987);
    found = 0;
    for (int i = 0; i < 8 * SD && !found; i++) begin
      @(negedge clk);
      if (sel1 == 4'b1000) found = 1;
    end
    chk("sel1_digit3_seen", {31'd0, found}, 32'd1);
    chk("tube1_digit3", {24'd0, tube1}, 32'hF9);
    found = 0;
    for (int i = 0; i < 8 * SD && !found; i++) begin
      @(negedge clk);
      if (sel1 == 4'b0001) found = 1;
    end
    chk("sel1_digit0_seen", {31'd0, found}, 32'd1);
    chk("tube1_digit0", {24'd0, tube1}, 32'h99);
    chk("tube0_digit0", {24'd0, tube0}, 32'h80);

    // wrap from FFFFFFFF
    {dip3, dip2, dip1, dip0} = 32'hFFFF_FFFF;
    press(1, 5);
    idle(200);
    chk("all_ones_led", led_light, 32'h0);
    press(0, 5);
    idle(200);
    chk("wrap_led", led_light, 32'hFFFF_FFFF);
    chk("wrap_frame", {24'd0, got_bytes[got_bytes.size() - 1]}, 32'h00);

    // two presses inside one frame time
    nb = got_bytes.size();
    press(0, 5);
    idle(3);
    press(0, 5);
    idle(300);
    chk("pair_frames", got_bytes.size(), nb + 2);
    if (got_bytes.size() >= nb + 2) begin
      chk("pair_first", {24'd0, got_bytes[nb]}, 32'h01);
      chk("pair_second", {24'd0, got_bytes[nb + 1]}, 32'h02);
    end

    // simultaneous events: load wins
    {dip3, dip2, dip1, dip0} = 32'hA5C3_0F96;
    press_both(6);
    idle(200);
    chk("load_wins_led", led_light, ~32'hA5C3_0F96);

    // randomized presses
    for (int i = 0; i < 60; i++) begin
      {dip3, dip2, dip1, dip0} = $urandom;
      {dip7, dip6, dip5, dip4} = $urandom;
      user_key[7:2] = 6'($urandom);
      uart_rxd = 1'($urandom);
      uart_rxd2 = 1'($urandom);
      case ($urandom_range(0, 2))
        0: press(0, $urandom_range(1, 8));
        1: press(1, $urandom_range(1, 8));
        default: press_both($urandom_range(1, 8));
      endcase
      idle($urandom_range(1, 150));
    end
    user_key[7:2] = '1;
    idle(400);

    // loopback is combinational
    for (int i = 0; i < 4; i++) begin
      uart_rxd2 = ~uart_rxd2;
      #1 chk("loopback", {31'd0, uart_txd2}, {31'd0, uart_rxd2});
    end
    idle(2);
    chk("frames_drained", exp_q.size(), 0);

    // reset in the middle of a frame
    mon_en = 1'b0;
    idle(20);
    press(0, 5);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (!uart_txd) found = 1;
    end
    chk("abort_frame_started", {31'd0, found}, 32'd1);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    user_key[0] = 1'b0;
    #1;
    chk("abort_txd", {31'd0, uart_txd}, 32'd1);
    chk("abort_led", led_light, 32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(30);
    chk("held_through_reset_led", led_light, 32'hFFFF_FFFF);
    chk("held_through_reset_txd", {31'd0, uart_txd}, 32'd1);
    user_key[0] = 1'b1;
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
